hack_memory: RTL and testbench

HACK_MEMORY -- requirements
Module: hack_memory

---
 rtl/hack_memory.sv | 114 +++++++++++
 tb/tb_hack_memory.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_memory.sv
// Hack computer memory block: a loader fills the instruction ROM while the CPU is held
// in reset, then the CPU runs against the ROM, the data RAM and a read-only keyboard port.
module hack_memory #(
    parameter int N      = 16,
    parameter int ROM_AW = 10,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      PC,
    input  logic [N-1:0]      addRAM,
    input  logic [N-1:0]      inRAM,
    input  logic              enM,
    output logic [N-1:0]      outROM,
    output logic [N-1:0]      outRAM,
    output logic              cpu_rst,
    input  logic              ld_valid,
    input  logic [N-1:0]      ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [N-1:0]      kbd,
    output logic [ROM_AW:0]   loaded_words
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [N-1:0]    KBD_ADDR = N'(16'h6000);
    localparam logic [ROM_AW:0] ONE      = (ROM_AW+1)'(1);

    state_e            state_q, state_d;
    logic [ROM_AW:0]   loaded_words_q, loaded_words_d;
    logic [N-1:0]      rom_mem [2**ROM_AW];
    logic [N-1:0]      ram_mem [2**RAM_AW];

    logic              rom_we;
    logic              ram_we;
    logic [ROM_AW-1:0] wr_ptr;
    logic [ROM_AW-1:0] rom_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              pc_in_rom;
    logic              rom_word_valid;
    logic              add_in_ram;
    logic              add_is_kbd;

    // Loading is strictly sequential from address 0, so the words written since reset are
    // exactly those below loaded_words; anything above reads as cleared without resetting the array.
    assign wr_ptr         = loaded_words_q[ROM_AW-1:0];
    assign rom_idx        = PC[ROM_AW-1:0];
    assign ram_idx        = addRAM[RAM_AW-1:0];
    assign pc_in_rom      = (PC >> ROM_AW) == '0;
    assign rom_word_valid = {1'b0, rom_idx} < loaded_words_q;
    assign add_in_ram     = (addRAM >> RAM_AW) == '0;
    assign add_is_kbd     = addRAM == KBD_ADDR;
    assign loaded_words   = loaded_words_q;

    always_comb begin
        state_d        = state_q;
        loaded_words_d = loaded_words_q;
        rom_we         = 1'b0;
        ram_we         = 1'b0;
        ld_ready       = 1'b0;
        cpu_rst        = 1'b0;
        outROM         = '0;
        outRAM         = '0;
        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                cpu_rst  = 1'b1;
                if (ld_valid) begin
                    rom_we         = 1'b1;
                    loaded_words_d = loaded_words_q + ONE;
                    if (ld_last || (wr_ptr == '1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                ram_we = enM && add_in_ram;
                if (pc_in_rom && rom_word_valid) begin
                    outROM = rom_mem[rom_idx];
                end
                if (add_in_ram) begin
                    outRAM = ram_mem[ram_idx];
                end else if (add_is_kbd) begin
                    outRAM = kbd;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= LOAD;
            loaded_words_q <= '0;
        end else begin
            state_q        <= state_d;
            loaded_words_q <= loaded_words_d;
        end
    end

    // Storage arrays carry no reset; RAM contents are deliberately left as they were.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[wr_ptr] <= ld_data;
        end
        if (ram_we) begin
            ram_mem[ram_idx] <= inRAM;
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
// Randomized self-checking bench for hack_memory, compared against a word-level model
// of the ROM, RAM and load/run behaviour.
module tb_hack_memory;

    logic        clk;
    logic        rst;
    logic [15:0] PC, addRAM, inRAM, kbd, ld_data;
    logic        enM, ld_valid, ld_last;
    logic [15:0] outROM, outRAM;
    logic        cpu_rst, ld_ready;
    logic [10:0] loaded_words;

    int n_cmp;
    int n_fail;

    logic [15:0] m_rom [1024];
    logic [15:0] m_ram [1024];
    bit          m_ram_ok [1024];
    int          m_loaded;
    bit          m_run;

    hack_memory #(.N(16), .ROM_AW(10), .RAM_AW(10)) dut (
        .clk(clk), .rst(rst), .PC(PC), .addRAM(addRAM), .inRAM(inRAM), .enM(enM),
        .outROM(outROM), .outRAM(outRAM), .cpu_rst(cpu_rst), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .kbd(kbd),
        .loaded_words(loaded_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_rom(input logic [15:0] pc);
        if (!m_run || pc >= 16'd1024) return 16'h0000;
        return m_rom[pc[9:0]];
    endfunction

    function automatic logic [15:0] exp_ram(input logic [15:0] a);
        if (!m_run) return 16'h0000;
        if (a < 16'd1024) return m_ram[a[9:0]];
        if (a == 16'h6000) return kbd;
        return 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_rom[i]    = 16'h0000;
            m_ram_ok[i] = 1'b0;
        end
        m_loaded = 0;
        m_run    = 1'b0;
    endtask

    // One rising edge: the model absorbs the inputs present just before the edge.
    task automatic tick();
        if (!m_run) begin
            if (ld_valid) begin
                m_rom[m_loaded] = ld_data;
                m_loaded++;
                if (ld_last || m_loaded == 1024) m_run = 1'b1;
            end
        end else if (enM && addRAM < 16'd1024) begin
            m_ram[addRAM[9:0]]    = inRAM;
            m_ram_ok[addRAM[9:0]] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        enM      = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        PC     = 16'h0001;
        addRAM = 16'h6000;
        kbd    = 16'h00FF;
        #1;
        n_cmp++; if (loaded_words !== 11'd0) begin n_fail++; $display("FAIL reset_loaded: got %0d expected 0", loaded_words); end
        n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        n_cmp++; if (outROM !== 16'h0000) begin n_fail++; $display("FAIL reset_outROM: got %h expected 0000", outROM); end
        n_cmp++; if (outRAM !== 16'h0000) begin n_fail++; $display("FAIL reset_outRAM: got %h expected 0000", outRAM); end
        release_reset();
    endtask

    task automatic test_load_basic();
        load_word(16'h0005, 1'b0);
        load_word(16'hEC10, 1'b0);
        PC = 16'h0000;
        #1;
        n_cmp++; if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL basic_midload_ctrl: got ready=%b cpu_rst=%b expected 1/1", ld_ready, cpu_rst); end
        n_cmp++; if (outROM !== 16'h0000) begin n_fail++; $display("FAIL basic_load_outROM: got %h expected 0000", outROM); end
        load_word(16'hE308, 1'b1);
        n_cmp++; if (loaded_words !== 11'd3) begin n_fail++; $display("FAIL basic_loaded: got %0d expected 3", loaded_words); end
        n_cmp++; if (ld_ready !== 1'b0 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL basic_run_ctrl: got ready=%b cpu_rst=%b expected 0/0", ld_ready, cpu_rst); end
        PC = 16'h0001;
        #1;
        n_cmp++; if (outROM !== 16'hEC10) begin n_fail++; $display("FAIL basic_pc1: got %h expected EC10", outROM); end
        PC = 16'h0003;
        #1;
        n_cmp++; if (outROM !== 16'h0000) begin n_fail++; $display("FAIL basic_pc3: got %h expected 0000", outROM); end
        for (int i = 0; i < 16; i++) begin
            PC = (i < 12) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            #1;
            n_cmp++; if (outROM !== exp_rom(PC)) begin n_fail++; $display("FAIL basic_rand_pc %h: got %h expected %h", PC, outROM, exp_rom(PC)); end
        end
    endtask

    task automatic test_ram();
        enM = 1'b1; addRAM = 16'h0000; inRAM = 16'h0F0F;
        tick();
        addRAM = 16'h0010; inRAM = 16'h1234;
        tick();
        enM = 1'b0;
        #1;
        n_cmp++; if (outRAM !== 16'h1234) begin n_fail++; $display("FAIL ram_write: got %h expected 1234", outRAM); end
        enM = 1'b1; inRAM = 16'h5678;
        #1;
        n_cmp++; if (outRAM !== 16'h1234) begin n_fail++; $display("FAIL ram_rdw_before: got %h expected 1234", outRAM); end
        tick();
        n_cmp++; if (outRAM !== 16'h5678) begin n_fail++; $display("FAIL ram_rdw_after: got %h expected 5678", outRAM); end
        addRAM = 16'h0400; inRAM = 16'hBEEF;
        tick();
        enM = 1'b0;
        #1;
        n_cmp++; if (outRAM !== 16'h0000) begin n_fail++; $display("FAIL ram_oob_read: got %h expected 0000", outRAM); end
        addRAM = 16'h0000;
        #1;
        n_cmp++; if (outRAM !== 16'h0F0F) begin n_fail++; $display("FAIL ram_oob_alias: got %h expected 0F0F", outRAM); end
        for (int i = 0; i < 16; i++) begin
            enM = 1'b1; addRAM = 16'(i); inRAM = 16'($urandom);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            int r;
            r      = $urandom_range(0, 9);
            addRAM = (r < 6) ? 16'($urandom_range(0, 15)) :
                     (r < 8) ? 16'h6000 :
                     (r == 8) ? 16'($urandom_range(16'h0400, 16'h5FFF)) :
                                16'($urandom_range(16'h6001, 16'hFFFF));
            enM    = 1'($urandom);
            inRAM  = 16'($urandom);
            kbd    = 16'($urandom);
            #1;
            if (!(addRAM < 16'd1024 && !m_ram_ok[addRAM[9:0]])) begin
                n_cmp++; if (outRAM !== exp_ram(addRAM)) begin n_fail++; $display("FAIL ram_rand %h: got %h expected %h", addRAM, outRAM, exp_ram(addRAM)); end
            end
            tick();
        end
        enM = 1'b0;
    endtask

    task automatic test_kbd();
        kbd = 16'h0041; addRAM = 16'h6000;
        #1;
        n_cmp++; if (outRAM !== 16'h0041) begin n_fail++; $display("FAIL kbd_read: got %h expected 0041", outRAM); end
        enM = 1'b1; inRAM = 16'hFFFF;
        tick();
        enM = 1'b0;
        n_cmp++; if (outRAM !== 16'h0041) begin n_fail++; $display("FAIL kbd_write_ignored: got %h expected 0041", outRAM); end
        kbd = 16'h1234;
        #1;
        n_cmp++; if (outRAM !== 16'h1234) begin n_fail++; $display("FAIL kbd_comb: got %h expected 1234", outRAM); end
    endtask

    task automatic test_load_enm();
        enM = 1'b1; addRAM = 16'h0001; inRAM = 16'h1111;
        tick();
        do_reset();
        release_reset();
        enM = 1'b1; addRAM = 16'h0001; inRAM = 16'hAAAA;
        tick();
        tick();
        n_cmp++; if (outRAM !== 16'h0000) begin n_fail++; $display("FAIL enm_load_outRAM: got %h expected 0000", outRAM); end
        tick();
        load_word(16'h7777, 1'b1);
        enM = 1'b0;
        #1;
        n_cmp++; if (outRAM === 16'hAAAA) begin n_fail++; $display("FAIL enm_load_write: got %h required anything but AAAA", outRAM); end
    endtask

    task automatic test_gapped_reset();
        do_reset();
        release_reset();
        for (int w = 0; w < 2; w++) begin
            load_word(16'($urandom) | 16'h0001, 1'b0);
            n_cmp++; if (loaded_words !== 11'(m_loaded)) begin n_fail++; $display("FAIL gap_count w%0d: got %0d expected %0d", w, loaded_words, m_loaded); end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                ld_data = 16'($urandom);
                ld_last = 1'($urandom);
                tick();
            end
            ld_last = 1'b0;
            n_cmp++; if (loaded_words !== 11'(m_loaded) || ld_ready !== 1'b1) begin n_fail++; $display("FAIL gap_idle w%0d: got %0d/%b expected %0d/1", w, loaded_words, ld_ready, m_loaded); end
        end
        do_reset();
        n_cmp++; if (loaded_words !== 11'd0) begin n_fail++; $display("FAIL gap_reset_count: got %0d expected 0", loaded_words); end
        n_cmp++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL gap_reset_cpu_rst: got %b expected 1", cpu_rst); end
        release_reset();
        load_word(16'h0000, 1'b1);
        PC = 16'h0000;
        #1;
        n_cmp++; if (outROM !== 16'h0000) begin n_fail++; $display("FAIL gap_reload_pc0: got %h expected 0000", outROM); end
        PC = 16'h0001;
        #1;
        n_cmp++; if (outROM !== exp_rom(PC) || outROM !== 16'h0000) begin n_fail++; $display("FAIL gap_reload_pc1: got %h expected 0000", outROM); end
    endtask

    task automatic test_load_full();
        do_reset();
        release_reset();
        for (int i = 0; i < 1023; i++) load_word(16'($urandom), 1'b0);
        n_cmp++; if (ld_ready !== 1'b1 || loaded_words !== 11'd1023) begin n_fail++; $display("FAIL full_pre_last: got ready=%b count=%0d expected 1/1023", ld_ready, loaded_words); end
        load_word(16'($urandom), 1'b0);
        n_cmp++; if (loaded_words !== 11'd1024) begin n_fail++; $display("FAIL full_count: got %0d expected 1024", loaded_words); end
        n_cmp++; if (cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_run_ctrl: got cpu_rst=%b ready=%b expected 0/0", cpu_rst, ld_ready); end
        ld_valid = 1'b1; ld_data = 16'hDEAD; ld_last = 1'b1;
        tick();
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        n_cmp++; if (loaded_words !== 11'd1024) begin n_fail++; $display("FAIL full_frozen: got %0d expected 1024", loaded_words); end
        PC = 16'h0000;
        #1;
        n_cmp++; if (outROM !== exp_rom(PC)) begin n_fail++; $display("FAIL full_pc0: got %h expected %h", outROM, exp_rom(PC)); end
        PC = 16'h03FF;
        #1;
        n_cmp++; if (outROM !== exp_rom(PC)) begin n_fail++; $display("FAIL full_pc3ff: got %h expected %h", outROM, exp_rom(PC)); end
        PC = 16'h0400;
        #1;
        n_cmp++; if (outROM !== 16'h0000) begin n_fail++; $display("FAIL full_pc400: got %h expected 0000", outROM); end
        for (int i = 0; i < 30; i++) begin
            PC = (i % 5 == 4) ? 16'($urandom) : 16'($urandom_range(0, 1023));
            #1;
            n_cmp++; if (outROM !== exp_rom(PC)) begin n_fail++; $display("FAIL full_rand_pc %h: got %h expected %h", PC, outROM, exp_rom(PC)); end
        end
    endtask

    task automatic test_random_load();
        int nw;
        do_reset();
        release_reset();
        nw = $urandom_range(1, 20);
        for (int w = 0; w < nw; w++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            load_word(16'($urandom), (w == nw - 1));
        end
        n_cmp++; if (loaded_words !== 11'(nw)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", loaded_words, nw); end
        for (int i = 0; i < 20; i++) begin
            PC = 16'($urandom_range(0, 31));
            #1;
            n_cmp++; if (outROM !== exp_rom(PC)) begin n_fail++; $display("FAIL rand_pc %h: got %h expected %h", PC, outROM, exp_rom(PC)); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0;
        PC = '0; addRAM = '0; inRAM = '0; kbd = '0; ld_data = '0;
        enM = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_basic();
        test_ram();
        test_kbd();
        test_load_enm();
        test_gapped_reset();
        test_load_full();
        test_random_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
